// File: rtl/tboom_rename_map_table.sv
// Two-wide register rename map table fed by tboom_freelist_buffer pops.
// Define TBOOM_RMT_CKPT_EN to add map snapshot checkpoint/restore support.
module tboom_rename_map_table #(
    parameter int AREG_WIDTH = 5,
    parameter int PREG_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AREG_WIDTH-1:0] i0_rs1,
    input  logic [AREG_WIDTH-1:0] i0_rs2,
    input  logic [AREG_WIDTH-1:0] i0_rd,
    input  logic                  i0_rd_en,
    input  logic [AREG_WIDTH-1:0] i1_rs1,
    input  logic [AREG_WIDTH-1:0] i1_rs2,
    input  logic [AREG_WIDTH-1:0] i1_rd,
    input  logic                  i1_rd_en,
    output logic                  fl_i0_read_enable,
    output logic                  fl_i1_read_enable,
    input  logic [PREG_WIDTH-1:0] fl_i0_data,
    input  logic [PREG_WIDTH-1:0] fl_i1_data,
    input  logic                  fl_empty,
    input  logic                  fl_one_remaining,
    output logic                  fl_checkpoint,
    output logic                  fl_restore,
    input  logic                  checkpoint,
    input  logic                  restore,
    output logic                  ckpt_done,
    output logic                  out_valid,
    output logic [PREG_WIDTH-1:0] i0_prs1,
    output logic [PREG_WIDTH-1:0] i0_prs2,
    output logic [PREG_WIDTH-1:0] i0_prd,
    output logic [PREG_WIDTH-1:0] i0_stale_prd,
    output logic [PREG_WIDTH-1:0] i1_prs1,
    output logic [PREG_WIDTH-1:0] i1_prs2,
    output logic [PREG_WIDTH-1:0] i1_prd,
    output logic [PREG_WIDTH-1:0] i1_stale_prd
);
    localparam int NREG = 1 << AREG_WIDTH;

    logic [PREG_WIDTH-1:0] map      [NREG];
    logic [PREG_WIDTH-1:0] map_next [NREG];

    logic                  s1_valid, s1_a0, s1_a1;
    logic [AREG_WIDTH-1:0] s1_i0_rs1, s1_i0_rs2, s1_i0_rd;
    logic [AREG_WIDTH-1:0] s1_i1_rs1, s1_i1_rs2, s1_i1_rd;

    logic                  a0_in, a1_in, fl_block, accept, restore_eff, s2_fire;
    logic [1:0]            need;
    logic [PREG_WIDTH-1:0] prd0, prd1;

    // Writes to arch register 0 never allocate a physical register.
    assign a0_in    = i0_rd_en && (i0_rd != '0);
    assign a1_in    = i1_rd_en && (i1_rd != '0);
    assign need     = {1'b0, a0_in} + {1'b0, a1_in};
    assign fl_block = ((need == 2'd2) && (fl_empty || fl_one_remaining)) ||
                      ((need == 2'd1) && fl_empty);

`ifdef TBOOM_RMT_CKPT_EN
    logic [PREG_WIDTH-1:0] snapshot [NREG];
    logic                  ckpt_pending, ckpt_q, ckpt_active, ckpt_fire;

    assign restore_eff   = restore && !rst;
    assign ckpt_active   = ckpt_pending || (checkpoint && !ckpt_q);
    assign ckpt_fire     = ckpt_active && !s1_valid && !restore && !rst;
    assign in_ready      = !rst && !restore && !ckpt_active && !fl_block;
    assign fl_checkpoint = ckpt_fire;
    assign ckpt_done     = ckpt_fire;
    assign fl_restore    = restore_eff;

    // Snapshot waits for stage 1 to drain so no popped tag is lost from it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ckpt_pending <= 1'b0;
            ckpt_q       <= 1'b0;
            for (int i = 0; i < NREG; i++) snapshot[i] <= PREG_WIDTH'(i);
        end else begin
            ckpt_q <= checkpoint;
            if (restore || ckpt_fire) ckpt_pending <= 1'b0;
            else if (ckpt_active)     ckpt_pending <= 1'b1;
            if (ckpt_fire) snapshot <= map_next;
        end
    end
`else
    logic unused_ckpt;
    assign unused_ckpt   = checkpoint ^ restore;
    assign restore_eff   = 1'b0;
    assign in_ready      = !rst && !fl_block;
    assign fl_checkpoint = 1'b0;
    assign ckpt_done     = 1'b0;
    assign fl_restore    = 1'b0;
`endif

    // Pops are packed: a lone slot-1 allocation uses the slot-0 freelist port.
    assign accept            = in_valid && in_ready;
    assign fl_i0_read_enable = accept && (a0_in || a1_in);
    assign fl_i1_read_enable = accept && a0_in && a1_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a0     <= 1'b0;
            s1_a1     <= 1'b0;
            s1_i0_rs1 <= '0;
            s1_i0_rs2 <= '0;
            s1_i0_rd  <= '0;
            s1_i1_rs1 <= '0;
            s1_i1_rs2 <= '0;
            s1_i1_rd  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a0     <= a0_in;
                s1_a1     <= a1_in;
                s1_i0_rs1 <= i0_rs1;
                s1_i0_rs2 <= i0_rs2;
                s1_i0_rd  <= i0_rd;
                s1_i1_rs1 <= i1_rs1;
                s1_i1_rs2 <= i1_rs2;
                s1_i1_rd  <= i1_rd;
            end
        end
    end

    assign s2_fire = s1_valid && !restore_eff;
    assign prd0    = s1_a0 ? fl_i0_data : '0;
    assign prd1    = !s1_a1 ? '0 : (s1_a0 ? fl_i1_data : fl_i0_data);

    function automatic logic [PREG_WIDTH-1:0] lookup(input logic [AREG_WIDTH-1:0] idx);
        if (idx == '0) return '0;
        return map[idx];
    endfunction

    // Slot 1 is program-later, so it sees slot 0's fresh destination.
    function automatic logic [PREG_WIDTH-1:0] lookup_i1(input logic [AREG_WIDTH-1:0] idx);
        if (s1_a0 && (idx == s1_i0_rd)) return prd0;
        return lookup(idx);
    endfunction

    always_comb begin
        map_next = map;
        if (s2_fire && s1_a0) map_next[s1_i0_rd] = prd0;
        if (s2_fire && s1_a1) map_next[s1_i1_rd] = prd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) map[i] <= PREG_WIDTH'(i);
`ifdef TBOOM_RMT_CKPT_EN
        end else if (restore_eff) begin
            map <= snapshot;
`endif
        end else begin
            map <= map_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            i0_prs1      <= '0;
            i0_prs2      <= '0;
            i0_prd       <= '0;
            i0_stale_prd <= '0;
            i1_prs1      <= '0;
            i1_prs2      <= '0;
            i1_prd       <= '0;
            i1_stale_prd <= '0;
        end else begin
            out_valid <= s2_fire;
            if (s2_fire) begin
                i0_prs1      <= lookup(s1_i0_rs1);
                i0_prs2      <= lookup(s1_i0_rs2);
                i0_prd       <= prd0;
                i0_stale_prd <= s1_a0 ? map[s1_i0_rd] : '0;
                i1_prs1      <= lookup_i1(s1_i1_rs1);
                i1_prs2      <= lookup_i1(s1_i1_rs2);
                i1_prd       <= prd1;
                i1_stale_prd <= !s1_a1 ? '0 :
                                ((s1_a0 && (s1_i1_rd == s1_i0_rd)) ? prd0 : map[s1_i1_rd]);
            end
        end
    end
endmodule

// File: doc/tboom_rename_map_table.md
Name: tboom_rename_map_table

Overview:
Two-wide register rename map table. It sits directly downstream of tboom_freelist_buffer and consumes the physical registers that block pops. For each rename group it:
- translates architectural source/destination indices to physical tags,
- allocates new destination tags from the freelist,
- reports the stale mapping for later release.

Map checkpoint/restore is coordinated with the freelist's own checkpoint/restore so both rewind together on a flush.

Parameters:
AREG_WIDTH, 5, architectural register index width (2**AREG_WIDTH entries).
PREG_WIDTH, 6, physical register tag width; must match freelist DATA_WIDTH.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  rename group presented
in_ready  out  1  group accepted when in_valid&&in_ready at posedge
i0_rs1, i0_rs2, i0_rd  in  AREG_WIDTH  slot-0 arch indices
i0_rd_en  in  1  slot 0 writes a destination
i1_rs1, i1_rs2, i1_rd  in  AREG_WIDTH  slot-1 arch indices (program-later than slot 0)
i1_rd_en  in  1  slot 1 writes a destination
fl_i0_read_enable, fl_i1_read_enable  out  1  freelist pop requests
fl_i0_data, fl_i1_data  in  PREG_WIDTH  freelist pop data, valid the cycle after the pop
fl_empty, fl_one_remaining  in  1  freelist status
fl_checkpoint, fl_restore  out  1  freelist checkpoint/restore pulses
checkpoint  in  1  request map snapshot (level, held until ckpt_done)
restore  in  1  single-cycle flush: restore snapshot
ckpt_done  out  1  one-cycle pulse, snapshot taken
out_valid  out  1  renamed group valid
i0_prs1, i0_prs2, i0_prd, i0_stale_prd  out  PREG_WIDTH  slot-0 results
i1_prs1, i1_prs2, i1_prd, i1_stale_prd  out  PREG_WIDTH  slot-1 results

Behaviour:
- Reset (async, rst=1):
  - map[i]=i and snapshot[i]=i.
  - Stage-1 valid=0, checkpoint pending=0.
  - All outputs 0; in_ready=0 while rst is asserted.
- Arch register 0: never allocates.
  - rd_en with rd=0 is treated as rd_en=0.
  - prd=0, stale_prd=0.
  - Any source index 0 yields tag 0.
- Effective need: n = (i0_rd_en&&i0_rd!=0) + (i1_rd_en&&i1_rd!=0).
- in_ready is deasserted when any of:
  - rst;
  - restore;
  - checkpoint pending;
  - n==2 && (fl_empty||fl_one_remaining);
  - n==1 && fl_empty.
- Pop requests: fl_iX_read_enable is asserted combinationally only when in_valid&&in_ready&&slot X allocates.
  - If only i1 allocates, it uses fl_i0_read_enable/fl_i0_data (the freelist pop is packed).
- Stage 1 (accept edge E0): register arch indices and enables; set stage-1 valid.
- Stage 2 (edge E1), registered outputs:
  - Look up sources in the current map.
  - Write destinations into the map.
  - Load outputs; out_valid=1 for one cycle per group.
  - Latency: out_valid rises after E1, one cycle after acceptance. Throughput is one group per cycle. There is no downstream backpressure.
- Intra-group rules:
  - i1 source equal to i0 rd (allocating) gets i0_prd.
  - i1_stale_prd equals i0_prd when i1_rd==i0_rd.
  - If both slots write the same rd, the map ends with i1_prd.
- Back-to-back groups: the stage-2 write at E1 is visible to the next group's stage-2 lookup at E2, so no extra forwarding is required.
- Checkpoint:
  - Rising request sets pending; in_ready drops.
  - When stage-1 valid==0, in the same cycle: snapshot←map (including any stage-2 write that cycle), fl_checkpoint=1, ckpt_done=1, pending cleared.
- Restore (highest priority):
  - map←snapshot and fl_restore=1 in the same cycle.
  - Stage-1 valid cleared, so the in-flight group is dropped and out_valid=0 next cycle.
  - Pending checkpoint cancelled; in_ready=0 in that cycle.
- Simultaneous restore and checkpoint: restore wins; checkpoint is ignored.
- Mid-operation reset clears all state immediately.

Optional Feature:
TBOOM_RMT_CKPT_EN:
- Defined: snapshot storage and the checkpoint/restore behaviour above.
- Undefined: no snapshot registers; checkpoint and restore ignored; fl_checkpoint, fl_restore and ckpt_done tied 0; in_ready never gated by checkpoint.

Test Plan:
- After reset, freelist model yields 32,33,...: group i0 rs1=3 rs2=4 rd=5, i1 idle -> one cycle after accept: out_valid=1, i0_prs1=3, i0_prs2=4, i0_prd=32, i0_stale_prd=5; fl_i0_read_enable high exactly one cycle.
- i0 rd=7; i1 rs1=7 rd=7 -> i0_prd=32, i0_stale=7, i1_prs1=32, i1_prd=33, i1_stale=32; next group rs1=7 -> prs1=33.
- Consecutive groups: A rd=9 (->32), B in next cycle rs1=9 -> B prs1=32; group with rd=0, rd_en=1 -> no pop, prd=0.
- fl_one_remaining=1 with both slots allocating -> in_ready=0, no read enables; single-allocation group -> accepted.
- Hold checkpoint while a group is in flight -> ckpt_done and fl_checkpoint wait until stage 1 is empty; then rename rd=5->34 and pulse restore -> fl_restore=1; next lookup rs1=5 returns 5; in-flight group dropped.
- Assert rst mid-stream -> out_valid=0 immediately, map identity, in_ready=0 until rst deasserts.
